// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and the
// control decoders that sit directly downstream of it.
package instr_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        ERROR = 2'b11
    } state_e;

    // 01_00_00_00 selects the nop pin of all four 2-to-4 decoders
    localparam logic [7:0] SAFE_OPCODE = 8'h40;

    localparam int DEC1_MSB = 7;
    localparam int DEC1_LSB = 6;
    localparam int DEC2_MSB = 5;
    localparam int DEC2_LSB = 4;
    localparam int DEC3_MSB = 3;
    localparam int DEC3_LSB = 2;
    localparam int DEC4_MSB = 1;
    localparam int DEC4_LSB = 0;

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Fetches opcodes into an instruction register and holds each one on the
// decoder inputs for a fixed number of non-stalled execute cycles.
module instr_fetch_sequencer #(
    parameter int                 ADDR_W      = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter int                 EXEC_CYCLES = 1,
    parameter int                 TIMEOUT     = 16,
    parameter logic [7:0]         SAFE_OPCODE = 8'h40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              halt_req_i,
    input  logic              stall_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              mem_rd_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rd_valid_i,
    input  logic [7:0]        mem_rd_data_i,
    output logic [7:0]        dec_in_o,
    output logic              exec_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              fault_o
);
    import instr_fetch_sequencer_pkg::*;

    localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [EXEC_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              fault_q, fault_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= SAFE_OPCODE;
            exec_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            exec_cnt_q <= exec_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        exec_cnt_d = exec_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (run_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A valid on the last allowed cycle still wins over the timeout
                if (mem_rd_valid_i) begin
                    ir_d       = mem_rd_data_i;
                    pc_d       = pc_q + ADDR_W'(1);
                    exec_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = EXEC;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            EXEC: begin
                if (!stall_i) begin
                    if (exec_cnt_q == EXEC_LAST) begin
                        exec_cnt_d = '0;
                        if (jump_en_i) begin
                            pc_d = jump_addr_i;
                        end
                        state_d = halt_req_i ? IDLE : FETCH;
                    end else begin
                        exec_cnt_d = exec_cnt_q + EXEC_W'(1);
                    end
                end
            end
            ERROR: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd_req_o = (state_q == FETCH);
    assign mem_addr_o   = pc_q;
    assign pc_o         = pc_q;
    assign exec_valid_o = (state_q == EXEC);
    assign dec_in_o     = (state_q == EXEC) ? ir_q : SAFE_OPCODE;
    assign busy_o       = (state_q == FETCH) || (state_q == EXEC);
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer (EXEC_CYCLES=3, TIMEOUT=16).
module tb_instr_fetch_sequencer;

    typedef struct packed {
        logic       run;
        logic       halt;
        logic       stall;
        logic       jen;
        logic [7:0] jaddr;
        logic       valid;
        logic [7:0] data;
    } in_t;

    typedef struct packed {
        logic       req;
        logic [7:0] addr;
        logic [7:0] dec;
        logic       ev;
        logic       busy;
        logic       fault;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run, halt_req, stall, jump_en;
    logic [7:0] jump_addr;
    logic       mem_rd_req;
    logic [7:0] mem_addr;
    logic       mem_rd_valid;
    logic [7:0] mem_rd_data;
    logic [7:0] dec_in;
    logic       exec_valid;
    logic [7:0] pc;
    logic       busy;
    logic       fault;

    int   vectors = 0;
    int   misses  = 0;
    exp_t sb[$];
    vec_t table_v[5];

    always #5 clk = ~clk;

    instr_fetch_sequencer #(
        .ADDR_W(8), .RESET_PC(8'h00), .EXEC_CYCLES(3), .TIMEOUT(16), .SAFE_OPCODE(8'h40)
    ) dut (
        .clk(clk), .rst(rst), .run_i(run), .halt_req_i(halt_req), .stall_i(stall),
        .jump_en_i(jump_en), .jump_addr_i(jump_addr), .mem_rd_req_o(mem_rd_req),
        .mem_addr_o(mem_addr), .mem_rd_valid_i(mem_rd_valid), .mem_rd_data_i(mem_rd_data),
        .dec_in_o(dec_in), .exec_valid_o(exec_valid), .pc_o(pc), .busy_o(busy), .fault_o(fault)
    );

    function automatic in_t mkIn(logic r, logic h, logic s, logic j, logic [7:0] ja,
                                 logic v, logic [7:0] d);
        in_t i;
        i = '{run: r, halt: h, stall: s, jen: j, jaddr: ja, valid: v, data: d};
        return i;
    endfunction

    function automatic exp_t mkExp(logic rq, logic [7:0] a, logic [7:0] d,
                                   logic e, logic b, logic f);
        exp_t x;
        x = '{req: rq, addr: a, dec: d, ev: e, busy: b, fault: f};
        return x;
    endfunction

    function automatic exp_t expIdle(logic [7:0] a);  return mkExp(1'b0, a, 8'h40, 1'b0, 1'b0, 1'b0); endfunction
    function automatic exp_t expFetch(logic [7:0] a); return mkExp(1'b1, a, 8'h40, 1'b0, 1'b1, 1'b0); endfunction
    function automatic exp_t expExec(logic [7:0] a, logic [7:0] d); return mkExp(1'b0, a, d, 1'b1, 1'b1, 1'b0); endfunction
    function automatic exp_t expErr(logic [7:0] a);   return mkExp(1'b0, a, 8'h40, 1'b0, 1'b0, 1'b1); endfunction
    function automatic in_t  idleIn();                return mkIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00); endfunction
    function automatic in_t  validIn(logic [7:0] d);  return mkIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, d); endfunction

    task automatic compareOut(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            misses++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing to compare, required an entry", name);
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (mem_rd_req !== e.req || mem_addr !== e.addr || pc !== e.addr || dec_in !== e.dec ||
            exec_valid !== e.ev || busy !== e.busy || fault !== e.fault) begin
            misses++;
            $display("[TB] FAIL %s: got req=%0b addr=%h pc=%h dec=%h ev=%0b busy=%0b fault=%0b, required req=%0b addr=%h pc=%h dec=%h ev=%0b busy=%0b fault=%0b",
                     name, mem_rd_req, mem_addr, pc, dec_in, exec_valid, busy, fault,
                     e.req, e.addr, e.addr, e.dec, e.ev, e.busy, e.fault);
        end
    endtask

    task automatic applyStimulus(input in_t i, input exp_t e);
        @(negedge clk);
        run          = i.run;
        halt_req     = i.halt;
        stall        = i.stall;
        jump_en      = i.jen;
        jump_addr    = i.jaddr;
        mem_rd_valid = i.valid;
        mem_rd_data  = i.data;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name);
        @(posedge clk);
        #1;
        compareOut(name);
    endtask

    task automatic step(input string name, input in_t i, input exp_t e);
        applyStimulus(i, e);
        checkOutput(name);
    endtask

    task automatic checkNow(input string name, input exp_t e);
        sb.push_back(e);
        compareOut(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {run, halt_req, stall, jump_en, mem_rd_valid} = '0;
        jump_addr   = 8'h00;
        mem_rd_data = 8'h00;

        // Basic fetch of 8'hA5 held for three execute cycles, then the next fetch from pc=1
        table_v[0] = '{in: mkIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00), exp: expFetch(8'h00)};
        table_v[1] = '{in: validIn(8'hA5), exp: expExec(8'h01, 8'hA5)};
        table_v[2] = '{in: idleIn(),       exp: expExec(8'h01, 8'hA5)};
        table_v[3] = '{in: idleIn(),       exp: expExec(8'h01, 8'hA5)};
        table_v[4] = '{in: idleIn(),       exp: expFetch(8'h01)};

        #12;
        checkNow("reset_values", expIdle(8'h00));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step($sformatf("table%0d", i), table_v[i].in, table_v[i].exp);
        end

        // Slow memory: request and address held while valid is late
        for (int i = 0; i < 5; i++) begin
            step($sformatf("delay%0d", i), idleIn(), expFetch(8'h01));
        end
        step("delay_valid", validIn(8'h5A), expExec(8'h02, 8'h5A));

        // halt on a non-final cycle is ignored; two stall cycles stretch EXEC
        step("halt_early", mkIn(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00), expExec(8'h02, 8'h5A));
        step("stall0", mkIn(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00), expExec(8'h02, 8'h5A));
        step("stall1", mkIn(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00), expExec(8'h02, 8'h5A));
        step("post_stall", idleIn(), expExec(8'h02, 8'h5A));
        step("jump_halt", mkIn(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00), expIdle(8'h3C));

        step("idle_ignore", mkIn(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 8'hFF), expIdle(8'h3C));
        step("run_from_3c", mkIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00), expFetch(8'h3C));
        step("fetch_3c", validIn(8'h11), expExec(8'h3D, 8'h11));
        step("exec_3d_a", idleIn(), expExec(8'h3D, 8'h11));
        step("exec_3d_b", idleIn(), expExec(8'h3D, 8'h11));
        step("jump_ff", mkIn(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00), expFetch(8'hFF));

        // Fetch at all-ones wraps the pc to zero
        step("wrap", validIn(8'h22), expExec(8'h00, 8'h22));
        step("wrap_a", idleIn(), expExec(8'h00, 8'h22));
        step("wrap_b", idleIn(), expExec(8'h00, 8'h22));
        step("wrap_fetch", idleIn(), expFetch(8'h00));

        // Asynchronous reset mid-fetch, then a late valid arrives in IDLE
        #2 rst = 1'b1;
        #1 checkNow("rst_async", expIdle(8'h00));
        @(negedge clk);
        rst = 1'b0;
        step("late_valid", validIn(8'h77), expIdle(8'h00));

        // Valid on the last allowed fetch cycle beats the timeout
        step("run_tmo", mkIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00), expFetch(8'h00));
        for (int i = 0; i < 15; i++) begin
            step($sformatf("wait%0d", i), idleIn(), expFetch(8'h00));
        end
        step("valid_wins", validIn(8'hC3), expExec(8'h01, 8'hC3));
        step("exec_c3_a", idleIn(), expExec(8'h01, 8'hC3));
        step("exec_c3_b", idleIn(), expExec(8'h01, 8'hC3));
        step("fetch_1", idleIn(), expFetch(8'h01));

        // Sixteen empty fetch cycles trip the sticky fault
        for (int i = 0; i < 15; i++) begin
            step($sformatf("tmo%0d", i), idleIn(), expFetch(8'h01));
        end
        step("timeout", idleIn(), expErr(8'h01));
        step("err_run", mkIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00), expErr(8'h01));
        step("err_valid", validIn(8'h99), expErr(8'h01));

        #2 rst = 1'b1;
        #1 checkNow("rst_clears_fault", expIdle(8'h00));
        @(negedge clk);
        rst = 1'b0;
        step("after_clear", idleIn(), expIdle(8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
